// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
package prio_enc_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   MAX_N      = 256;

   // Clearing the lowest set bit leaves a nonzero value iff two or more were set.
   function automatic logic multi_hot(input logic [MAX_N-1:0] v);
      return (v & (v - 1'b1)) != '0;
   endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// Circular descending search: start, start-1, ..., 0, N-1, ... first set bit wins.
module prio_pick #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         any
);

   int s;
   int j;

   always_comb begin
      idx = '0;
      any = |req;
      s   = int'(start);
      j   = 0;
      // Walk from farthest to nearest so the nearest hit is the last assignment.
      for (int k = N - 1; k >= 0; k--) begin
         j = (s >= k) ? (s - k) : (s - k + N);
         if (req[j]) idx = W'(j);
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin arbitration and a
// valid/ready output slot.
module prio_encoder_rr
   import prio_enc_pkg::*;
#(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         mode,
   input  logic [N-1:0] in_req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic         out_multi
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic         valid_q, valid_d;
   logic [W-1:0] idx_q, idx_d;
   logic         multi_q, multi_d;
   logic [W-1:0] ptr_q, ptr_d;

   logic [W-1:0]     start;
   logic [W-1:0]     pick_idx;
   logic             pick_any;
   logic [MAX_N-1:0] req_ext;
   logic             slot_free;
   logic             capture;

   assign start     = (mode == MODE_RR) ? ptr_q : LAST;
   assign req_ext   = MAX_N'(in_req);
   assign slot_free = !valid_q || out_ready;
   assign capture   = enable && pick_any && slot_free;

   prio_pick #(.N(N), .W(W)) u_pick (
      .req   (in_req),
      .start (start),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      multi_d = multi_q;
      ptr_d   = ptr_q;
      if (capture) begin
         valid_d = 1'b1;
         idx_d   = pick_idx;
         multi_d = multi_hot(req_ext);
         if (mode == MODE_RR)
            ptr_d = (pick_idx == '0) ? LAST : pick_idx - 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         multi_q <= 1'b0;
         ptr_q   <= LAST;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         multi_q <= multi_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_idx   = idx_q;
   assign out_multi = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr at N=16 and N=5.
module tb_prio_encoder_rr;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] in_req = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [3:0]  out_idx;
   logic        out_multi;

   logic        en5 = 1'b0;
   logic        mode5 = 1'b0;
   logic [4:0]  req5 = '0;
   logic        rdy5 = 1'b0;
   logic        val5;
   logic [2:0]  idx5;
   logic        multi5;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   prio_encoder_rr #(.N(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .mode      (mode),
      .in_req    (in_req),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_multi (out_multi)
   );

   prio_encoder_rr #(.N(5)) dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (en5),
      .mode      (mode5),
      .in_req    (req5),
      .out_ready (rdy5),
      .out_valid (val5),
      .out_idx   (idx5),
      .out_multi (multi5)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_multi", 32'(out_multi), 32'd0);
      #4 rst_n = 1'b1;
      step();

      // fixed priority
      enable = 1'b1; mode = 1'b0; out_ready = 1'b1; in_req = 16'h4005;
      step();
      check("fix_valid", 32'(out_valid), 32'd1);
      check("fix_idx14", 32'(out_idx), 32'd14);
      check("fix_multi1", 32'(out_multi), 32'd1);
      in_req = 16'h0010;
      step();
      check("fix_idx4", 32'(out_idx), 32'd4);
      check("fix_multi0", 32'(out_multi), 32'd0);
      in_req = 16'h0000;
      step();
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_idx_kept", 32'(out_idx), 32'd4);

      // round-robin, ptr untouched by fixed captures
      mode = 1'b1; in_req = 16'h8001;
      step(); check("rr_1", 32'(out_idx), 32'd15);
      step(); check("rr_2", 32'(out_idx), 32'd0);
      step(); check("rr_3", 32'(out_idx), 32'd15);
      step(); check("rr_4", 32'(out_idx), 32'd0);
      check("rr_valid", 32'(out_valid), 32'd1);
      in_req = 16'h0000;
      step();

      // backpressure
      mode = 1'b0; out_ready = 1'b0; in_req = 16'h1000;
      step();
      check("bp_cap", 32'(out_idx), 32'd12);
      in_req = 16'h0002;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_idx", 32'(out_idx), 32'd12);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      step();
      check("bp_next_idx", 32'(out_idx), 32'd1);
      check("bp_next_valid", 32'(out_valid), 32'd1);

      // enable low drains pending result but blocks capture
      enable = 1'b0; in_req = 16'h4000;
      step();
      check("en0_drain", 32'(out_valid), 32'd0);
      step();
      check("en0_idle", 32'(out_valid), 32'd0);
      enable = 1'b1; in_req = 16'h0000;
      step();
      check("empty_idle", 32'(out_valid), 32'd0);

      // mode switch keeps ptr: ptr is 15, RR capture of bit 4 leaves ptr=3
      mode = 1'b1; in_req = 16'h0010;
      step();
      check("ptr3_cap", 32'(out_idx), 32'd4);
      out_ready = 1'b0; in_req = 16'h0000;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_idx", 32'(out_idx), 32'd0);
      #2 rst_n = 1'b1;
      out_ready = 1'b1; in_req = 16'hFFFF;
      step();
      check("post_rst_idx", 32'(out_idx), 32'd15);
      check("post_rst_multi", 32'(out_multi), 32'd1);
      in_req = 16'h0000;

      // non-power-of-two N
      en5 = 1'b1; mode5 = 1'b1; rdy5 = 1'b1; req5 = 5'b10001;
      step(); check("n5_1", 32'(idx5), 32'd4);
      step(); check("n5_2", 32'(idx5), 32'd0);
      step(); check("n5_3", 32'(idx5), 32'd4);
      check("n5_range", 32'(idx5 <= 3'd4), 32'd1);
      check("n5_multi", 32'(multi5), 32'd1);
      req5 = 5'b00000; en5 = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
